// File: rtl/jelly_float_to_fixed_pkg.sv
// Shared float-format helpers for the float math blocks: field defaults, exponent bias and
// value classification (zero / normal / Inf / NaN).
package jelly_float_to_fixed_pkg;

   localparam int DEFAULT_EXP_WIDTH  = 8;
   localparam int DEFAULT_FRAC_WIDTH = 23;

   typedef enum logic [1:0] {
      FCLS_ZERO,
      FCLS_NORMAL,
      FCLS_INF,
      FCLS_NAN
   } float_class_t;

   function automatic int float_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   // Denormals share the zero class: they are flushed rather than converted.
   function automatic float_class_t float_classify(input logic exp_zero,
                                                   input logic exp_ones,
                                                   input logic frac_zero);
      if (exp_zero)  return FCLS_ZERO;
      if (!exp_ones) return FCLS_NORMAL;
      return frac_zero ? FCLS_INF : FCLS_NAN;
   endfunction

   // Shifts beyond this magnitude cannot change the result (all bits gone either way).
   function automatic int shift_limit(input int fixed_width, input int frac_width);
      return fixed_width + frac_width + 1;
   endfunction

endpackage

// File: rtl/jelly_float_to_fixed_shift.sv
// Combinational bidirectional barrel shifter driven by a signed amount (positive = left).
// overflow is sticky: set when any nonzero bit lands above the OUT_WIDTH result window.
module jelly_float_to_fixed_shift #(
   parameter int DATA_WIDTH  = 24,
   parameter int OUT_WIDTH   = 32,
   parameter int SHIFT_WIDTH = 7
) (
   input  logic                          [DATA_WIDTH-1:0] data,
   input  logic signed                  [SHIFT_WIDTH-1:0] shift,
   output logic                           [OUT_WIDTH-1:0] result,
   output logic                                           overflow
);

   localparam int WIDE_WIDTH = OUT_WIDTH + DATA_WIDTH;

   logic [WIDE_WIDTH-1:0]  wide;
   logic [SHIFT_WIDTH-1:0] amount;

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      wide     = '0;
      amount   = '0;
      overflow = 1'b0;
      if (shift >= 0) begin
         amount = shift;
         // A normal mantissa shifted this far can only leave zeros in the result window.
         if (amount >= SHIFT_WIDTH'(OUT_WIDTH)) begin
            overflow = |data;
         end else begin
            wide     = WIDE_WIDTH'(data) << amount;
            overflow = |wide[WIDE_WIDTH-1:OUT_WIDTH];
         end
      end else begin
         amount   = -shift;
         wide     = WIDE_WIDTH'(data) >> amount;
         overflow = |wide[WIDE_WIDTH-1:OUT_WIDTH];
      end
      result = wide[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/jelly_float_to_fixed.sv
// Four-stage float -> signed fixed-point converter with valid/ready and user sideband.
// Define JELLY_FLOAT_TO_FIXED_SATURATE_EN to saturate out-of-range results instead of wrapping.
module jelly_float_to_fixed
   import jelly_float_to_fixed_pkg::*;
#(
   parameter int EXP_WIDTH        = DEFAULT_EXP_WIDTH,
   parameter int EXP_OFFSET       = float_bias(EXP_WIDTH),
   parameter int FRAC_WIDTH       = DEFAULT_FRAC_WIDTH,
   parameter int FLOAT_WIDTH      = 1 + EXP_WIDTH + FRAC_WIDTH,
   parameter int FIXED_INT_WIDTH  = 16,
   parameter int FIXED_FRAC_WIDTH = 16,
   parameter int FIXED_WIDTH      = FIXED_INT_WIDTH + FIXED_FRAC_WIDTH,
   parameter int USER_WIDTH       = 0,
   parameter int USER_BITS        = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cke,

   input  logic [USER_BITS-1:0]   s_user,
   input  logic [FLOAT_WIDTH-1:0] s_float,
   input  logic                   s_valid,
   output logic                   s_ready,

   output logic [USER_BITS-1:0]   m_user,
   output logic [FIXED_WIDTH-1:0] m_fixed,
   output logic                   m_overflow,
   output logic                   m_valid,
   input  logic                   m_ready
);

   localparam int SH_LIMIT = shift_limit(FIXED_WIDTH, FRAC_WIDTH);
   localparam int SH_WIDTH = $clog2(SH_LIMIT + 1) + 1;
   localparam int SH_BASE  = FIXED_FRAC_WIDTH - EXP_OFFSET - FRAC_WIDTH;

   logic advance;
   assign advance = cke & (~m_valid | m_ready);
   assign s_ready = advance;

   // ---------------- stage 1: decode ----------------
   logic                       in_sign;
   logic [EXP_WIDTH-1:0]       in_exp;
   logic [FRAC_WIDTH-1:0]      in_frac;
   int                         sh_full;
   logic signed [SH_WIDTH-1:0] sh_clamped;

   assign in_sign = s_float[FLOAT_WIDTH-1];
   assign in_exp  = s_float[FRAC_WIDTH +: EXP_WIDTH];
   assign in_frac = s_float[FRAC_WIDTH-1:0];

   always_comb begin
      sh_full = int'(in_exp) + SH_BASE;
      if (sh_full > SH_LIMIT)       sh_clamped = SH_WIDTH'(SH_LIMIT);
      else if (sh_full < -SH_LIMIT) sh_clamped = SH_WIDTH'(-SH_LIMIT);
      else                          sh_clamped = SH_WIDTH'(sh_full);
   end

   logic                       st1_valid;
   logic [USER_BITS-1:0]       st1_user;
   logic                       st1_sign;
   float_class_t               st1_cls;
   logic [FRAC_WIDTH:0]        st1_mant;
   logic signed [SH_WIDTH-1:0] st1_sh;

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is written with non-blocking assignments so each stage captures the
      // previous stage's pre-edge value and the pipeline shifts by exactly one step.
      if (!reset) begin
         st1_valid <= 1'b0;
         st1_user  <= '0;
         st1_sign  <= 1'b0;
         st1_cls   <= FCLS_ZERO;
         st1_mant  <= '0;
         st1_sh    <= '0;
      end else if (advance) begin
         st1_valid <= s_valid;
         st1_user  <= s_user;
         st1_sign  <= in_sign;
         st1_cls   <= float_classify(in_exp == '0, &in_exp, in_frac == '0);
         st1_mant  <= {1'b1, in_frac};
         st1_sh    <= sh_clamped;
      end
   end

   // ---------------- stage 2: shift ----------------
   logic [FIXED_WIDTH-1:0] shift_mag;
   logic                   shift_ovf;

   jelly_float_to_fixed_shift #(
      .DATA_WIDTH  (FRAC_WIDTH + 1),
      .OUT_WIDTH   (FIXED_WIDTH),
      .SHIFT_WIDTH (SH_WIDTH)
   ) u_shift (
      .data     (st1_mant),
      .shift    (st1_sh),
      .result   (shift_mag),
      .overflow (shift_ovf)
   );

   logic                   st2_valid;
   logic [USER_BITS-1:0]   st2_user;
   logic                   st2_sign;
   float_class_t           st2_cls;
   logic [FIXED_WIDTH-1:0] st2_mag;
   logic                   st2_sticky;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st2_valid  <= 1'b0;
         st2_user   <= '0;
         st2_sign   <= 1'b0;
         st2_cls    <= FCLS_ZERO;
         st2_mag    <= '0;
         st2_sticky <= 1'b0;
      end else if (advance) begin
         st2_valid  <= st1_valid;
         st2_user   <= st1_user;
         st2_sign   <= st1_sign;
         st2_cls    <= st1_cls;
         st2_mag    <= shift_mag;
         st2_sticky <= shift_ovf;
      end
   end

   // ---------------- stage 3: range check and negate ----------------
`ifdef JELLY_FLOAT_TO_FIXED_SATURATE_EN
   localparam logic [FIXED_WIDTH-1:0] FIXED_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
   localparam logic [FIXED_WIDTH-1:0] FIXED_MIN = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
`endif

   logic                   range_ovf;
   logic [FIXED_WIDTH-1:0] signed_val;
   logic [FIXED_WIDTH-1:0] fixed_next;
   logic                   ovf_next;

   always_comb begin
      // Magnitude 2^(N-1) is only representable when negative.
      range_ovf  = st2_sticky |
                   (st2_mag[FIXED_WIDTH-1] & (~st2_sign | (|st2_mag[FIXED_WIDTH-2:0])));
      signed_val = st2_sign ? -st2_mag : st2_mag;
      fixed_next = '0;
      ovf_next   = 1'b0;
      case (st2_cls)
         FCLS_NORMAL: begin
            ovf_next   = range_ovf;
            fixed_next = signed_val;
`ifdef JELLY_FLOAT_TO_FIXED_SATURATE_EN
            if (range_ovf) fixed_next = st2_sign ? FIXED_MIN : FIXED_MAX;
`endif
         end
         FCLS_INF: begin
            ovf_next = 1'b1;
`ifdef JELLY_FLOAT_TO_FIXED_SATURATE_EN
            fixed_next = st2_sign ? FIXED_MIN : FIXED_MAX;
`endif
         end
         FCLS_NAN: begin
            ovf_next = 1'b1;
`ifdef JELLY_FLOAT_TO_FIXED_SATURATE_EN
            fixed_next = FIXED_MAX;
`endif
         end
         default: begin
            fixed_next = '0;
            ovf_next   = 1'b0;
         end
      endcase
   end

   logic                   st3_valid;
   logic [USER_BITS-1:0]   st3_user;
   logic [FIXED_WIDTH-1:0] st3_fixed;
   logic                   st3_ovf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st3_valid <= 1'b0;
         st3_user  <= '0;
         st3_fixed <= '0;
         st3_ovf   <= 1'b0;
      end else if (advance) begin
         st3_valid <= st2_valid;
         st3_user  <= st2_user;
         st3_fixed <= fixed_next;
         st3_ovf   <= ovf_next;
      end
   end

   // ---------------- stage 4: output register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid    <= 1'b0;
         m_user     <= '0;
         m_fixed    <= '0;
         m_overflow <= 1'b0;
      end else if (advance) begin
         m_valid    <= st3_valid;
         m_user     <= st3_user;
         m_fixed    <= st3_fixed;
         m_overflow <= st3_ovf;
      end
   end

endmodule

// File: tb/tb_jelly_float_to_fixed.sv
// Self-checking bench for jelly_float_to_fixed (Q16.16, default float format, 8-bit user).
// Expected values come from an arithmetic reference model plus hand-computed vectors.
module tb_jelly_float_to_fixed;

`ifdef JELLY_FLOAT_TO_FIXED_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        cke;
   logic [7:0]  s_user;
   logic [31:0] s_float;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  m_user;
   logic [31:0] m_fixed;
   logic        m_overflow;
   logic        m_valid;
   logic        m_ready;

   jelly_float_to_fixed #(
      .USER_WIDTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cke        (cke),
      .s_user     (s_user),
      .s_float    (s_float),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_user     (m_user),
      .m_fixed    (m_fixed),
      .m_overflow (m_overflow),
      .m_valid    (m_valid),
      .m_ready    (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: exact real value scaled by 2^16, magnitude truncated, then range-checked.
   function automatic logic [32:0] model(input logic [31:0] f);
      logic         sgn;
      int           e;
      int           sh;
      logic [255:0] mag;
      logic [31:0]  res;
      logic         ovf;
      sgn = f[31];
      e   = int'(f[30:23]);
      if (e == 0) return 33'd0;
      if (e == 255) begin
         if (!SAT_EN) return {1'b1, 32'd0};
         if (f[22:0] != 0 || !sgn) return {1'b1, 32'h7FFF_FFFF};
         return {1'b1, 32'h8000_0000};
      end
      sh  = e - 127 - 23 + 16;
      mag = 256'(f[22:0]) | (256'd1 << 23);
      mag = (sh >= 0) ? (mag << sh) : (mag >> (-sh));
      ovf = sgn ? (mag > 256'h8000_0000) : (mag > 256'h7FFF_FFFF);
      res = sgn ? (32'd0 - mag[31:0]) : mag[31:0];
      if (SAT_EN && ovf) res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {ovf, res};
   endfunction

   // Directed vectors: input, wrapped result, saturated result, overflow flag.
   localparam int NV = 15;
   logic [31:0] vf [NV] = '{32'h3FC0_0000, 32'hC020_0000, 32'h8000_0000, 32'hC700_0000,
                           32'h4700_0000, 32'h3700_0000, 32'h7F80_0000, 32'hFF80_0000,
                           32'h0000_0001, 32'h7FC0_0000, 32'h46FF_FE00, 32'hBF00_0000,
                           32'h4F00_0000, 32'hFF00_0000, 32'hC700_0001};
   logic [31:0] vr [NV] = '{32'h0001_8000, 32'hFFFD_8000, 32'h0000_0000, 32'h8000_0000,
                           32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                           32'h0000_0000, 32'h0000_0000, 32'h7FFF_0000, 32'hFFFF_8000,
                           32'h0000_0000, 32'h0000_0000, 32'h7FFF_FF00};
   logic [31:0] vs [NV] = '{32'h0001_8000, 32'hFFFD_8000, 32'h0000_0000, 32'h8000_0000,
                           32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                           32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_0000, 32'hFFFF_8000,
                           32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
   logic        vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   // ---------------- scoreboard / compare process ----------------
   typedef struct {
      logic [32:0] res;
      logic [7:0]  user;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          adv_cnt = 0;
   logic        adv;
   logic        hold_flag = 1'b0;
   logic [40:0] held;

   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         hold_flag = 1'b0;
      end else begin
         adv = cke & (~m_valid | m_ready);
         check("s_ready", s_ready, adv);
         if (hold_flag) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", {m_user, m_overflow, m_fixed}, held);
         end else if (m_valid) begin
            if (sb.size() == 0) check("unexpected_word", sb.size(), 1);
            else                check("latency", adv_cnt - sb[0].acc, 4);
         end
         if (m_valid && adv && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result", {m_overflow, m_fixed}, e.res);
            check("user", m_user, e.user);
         end
         hold_flag = m_valid & ~adv;
         held      = {m_user, m_overflow, m_fixed};
         if (s_valid && adv) sb.push_back('{model(s_float), s_user, adv_cnt});
         if (adv) adv_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_one(input logic [31:0] f, input logic [7:0] u,
                           input logic [32:0] want, input string name);
      int n;
      bit got;
      s_float = f;
      s_user  = u;
      s_valid = 1'b1;
      m_ready = 1'b1;
      cke     = 1'b1;
      @(negedge clk);
      check({name, "_accept"}, s_ready, 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
      got = 1'b0;
      for (n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (m_valid) got = 1'b1;
      end
      check({name, "_arrive"}, got, 1);
      if (got) check(name, {m_overflow, m_fixed}, want);
   endtask

   function automatic logic [31:0] rand_float();
      case ($urandom_range(0, 11))
         0:       return 32'h7F80_0000;
         1:       return 32'hFF80_0000;
         2:       return 32'h7FC0_0001;
         3:       return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
         4:       return {$urandom_range(0, 1) == 1, 8'($urandom_range(140, 254)), 23'($urandom)};
         default: return {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 142)), 23'($urandom)};
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int  n;
      int  stale;
      bit  taken;
      reset   = 1'b0;
      cke     = 1'b1;
      s_valid = 1'b0;
      s_float = '0;
      s_user  = '0;
      m_ready = 1'b1;

      // Reset state
      #23;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_fixed", m_fixed, 0);
      check("rst_m_overflow", m_overflow, 0);
      check("rst_m_user", m_user, 0);
      check("rst_s_ready", s_ready, 1);
      #4 reset = 1'b1;

      // Pin the reference model to hand-computed values
      for (int i = 0; i < NV; i++)
         check($sformatf("model_pin_%0d", i), model(vf[i]), {vo[i], SAT_EN ? vs[i] : vr[i]});

      // Directed conversions, boundaries and specials
      @(posedge clk);
      #1;
      for (int i = 0; i < NV; i++)
         send_one(vf[i], 8'(8'hA0 + i), {vo[i], SAT_EN ? vs[i] : vr[i]},
                  $sformatf("vec_%08h", vf[i]));

      // Stream with random back-pressure and clock-enable
      @(posedge clk);
      #1;
      for (int i = 0; i < 100; i++) begin
         s_float = rand_float();
         s_user  = 8'(i);
         s_valid = 1'b1;
         taken   = 1'b0;
         n       = 0;
         while (!taken && n < 1000) begin
            @(negedge clk);
            taken = s_ready;
            @(posedge clk);
            #1;
            cke     = ($urandom_range(0, 99) < 85);
            m_ready = ($urandom_range(0, 99) < 70);
            n++;
         end
         if (!taken) check("stream_accept", taken, 1);
      end
      s_valid = 1'b0;
      cke     = 1'b1;
      m_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("stream_drain", sb.size(), 0);

      // Reset with words in flight
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         s_float = 32'h3F80_0000 + 32'(i << 20);
         s_user  = 8'(8'h50 + i);
         s_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_m_fixed", m_fixed, 0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_valid) stale++;
      end
      check("no_stale_words", stale, 0);
      @(posedge clk);
      #1;
      send_one(32'h3FC0_0000, 8'h77, {1'b0, 32'h0001_8000}, "post_reset");

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
